inv_sub_bytes_seq: RTL and testbench

Iterative InvSubBytes engine for the AES-256 decryption datapath. It accepts one 128-bit state over a valid/ready handshake and passes its 16 bytes through LANES shared InverseSbox instances, LANES bytes per cycle. It returns the substituted state over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the decrypt round loop and trades latency for S-box area.

---
 rtl/aes_dec_pkg.sv | 22 ++
 rtl/InverseSbox.sv | 39 +++
 rtl/inv_sub_bytes_seq.sv | 112 +++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-256 decryption datapath: FSM state type,
// block size, and helpers for byte addressing and lane-count validation.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned AES_BYTES = 16;

    // Byte 0 is the most significant byte of the 128-bit state.
    function automatic logic [7:0] byte_of(input logic [127:0] s, input int unsigned k);
        return s[127-8*k -: 8];
    endfunction

    function automatic bit lanes_legal(input int unsigned n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

endpackage

// File: rtl/InverseSbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module InverseSbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] aff;

    always_comb begin
        aff = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        c   = gf_inv(aff);
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: substitutes a 128-bit state LANES bytes per cycle
// through shared inverse S-boxes, with valid/ready on both sides.
module inv_sub_bytes_seq
    import aes_dec_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned GROUPS = AES_BYTES / LANES;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    state_e         state_q;
    logic [GW-1:0]  grp_q;
    logic [127:0]   work_q;
    logic [127:0]   work_d;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [127:0]   out_state_q;
    logic           busy_q;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in[l] = byte_of(work_q, 32'(grp_q) * LANES + l);
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        InverseSbox u_sbox (
            .a (lane_in[g]),
            .c (lane_out[g])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            work_d[127-8*(32'(grp_q) * LANES + l) -: 8] = lane_out[l];
        end
    end

    // Outputs are registered alongside the state so that nothing downstream
    // sees a combinational path from the handshake inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grp_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_state;
                        grp_q      <= '0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    if (grp_q == GW'(GROUPS - 1)) begin
                        grp_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_state_q <= work_d;
                    end else begin
                        grp_q <= grp_q + GW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_state_q <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: main instance with LANES=4 plus one
// instance for each other legal lane count driven in lockstep.
module tb_inv_sub_bytes_seq;

    localparam logic [127:0] V_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R_SEQ = 128'h52096ad53036a538bf40a39e81f3d7fb;
    localparam logic [127:0] V_63  = {16{8'h63}};
    localparam logic [127:0] V_00  = {16{8'h00}};
    localparam logic [127:0] R_00  = {16{8'h52}};
    localparam logic [127:0] V_FF  = {16{8'hff}};
    localparam logic [127:0] R_FF  = {16{8'h7d}};
    localparam logic [127:0] SENT  = {16{8'haa}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic         lv_in_valid;
    logic         lv_out_ready;
    logic [127:0] lv_in_state;
    logic [3:0]   lv_in_ready;
    logic [3:0]   lv_out_valid;
    logic [3:0]   lv_busy;
    logic [127:0] lv_out_state [4];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(lv_in_valid), .in_ready(lv_in_ready[0]),
        .in_state(lv_in_state), .out_valid(lv_out_valid[0]), .out_ready(lv_out_ready),
        .out_state(lv_out_state[0]), .busy(lv_busy[0])
    );
    inv_sub_bytes_seq #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(lv_in_valid), .in_ready(lv_in_ready[1]),
        .in_state(lv_in_state), .out_valid(lv_out_valid[1]), .out_ready(lv_out_ready),
        .out_state(lv_out_state[1]), .busy(lv_busy[1])
    );
    inv_sub_bytes_seq #(.LANES(8)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(lv_in_valid), .in_ready(lv_in_ready[2]),
        .in_state(lv_in_state), .out_valid(lv_out_valid[2]), .out_ready(lv_out_ready),
        .out_state(lv_out_state[2]), .busy(lv_busy[2])
    );
    inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(lv_in_valid), .in_ready(lv_in_ready[3]),
        .in_state(lv_in_state), .out_valid(lv_out_valid[3]), .out_ready(lv_out_ready),
        .out_state(lv_out_state[3]), .busy(lv_busy[3])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        lv_in_valid = 1'b0; lv_out_ready = 1'b0; lv_in_state = '0;
        step(); step();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_state !== '0) $display("FAIL reset_out_state got %h want 0", out_state); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (lv_in_ready !== 4'hf) $display("FAIL reset_lanes_in_ready got %b want 1111", lv_in_ready); else passed++;
    endtask

    task automatic test_basic();
        int n;
        in_state = V_SEQ; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_state = '0;
        total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_busy got %b want 0", in_ready); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
        total++; if (out_state !== '0) $display("FAIL basic_partial_hidden got %h want 0", out_state); else passed++;
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        total++; if (n != 4) $display("FAIL basic_latency got %0d want 4", n); else passed++;
        total++; if (out_state !== R_SEQ) $display("FAIL basic_result got %h want %h", out_state, R_SEQ); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done got %b want 0", in_ready); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL basic_out_valid_fall got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_back got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] res[$];
        logic [127:0] r0;
        logic [127:0] r1;
        logic rdy;
        int second;
        second = 0;
        in_state = V_63; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_state = V_00;
        for (int i = 1; i <= 16; i++) begin
            rdy = in_ready;
            step();
            if (in_valid && rdy && second == 0) begin
                second = i;
                in_valid = 1'b0;
            end
            if (out_valid) res.push_back(out_state);
        end
        r0 = (res.size() > 0) ? res[0] : SENT;
        r1 = (res.size() > 1) ? res[1] : SENT;
        total++; if (second != 6) $display("FAIL b2b_spacing got %0d want 6", second); else passed++;
        total++; if (res.size() != 2) $display("FAIL b2b_result_count got %0d want 2", res.size()); else passed++;
        total++; if (r0 !== V_00) $display("FAIL b2b_first got %h want %h", r0, V_00); else passed++;
        total++; if (r1 !== R_00) $display("FAIL b2b_second got %h want %h", r1, R_00); else passed++;
    endtask

    task automatic test_hold();
        int n;
        in_state = V_SEQ; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        total++; if (n != 4) $display("FAIL hold_latency got %0d want 4", n); else passed++;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = {16{8'h11}};
            step();
            total++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid[%0d] got %b want 1", i, out_valid); else passed++;
            total++; if (out_state !== R_SEQ) $display("FAIL hold_out_state[%0d] got %h want %h", i, out_state, R_SEQ); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); else passed++;
        end
        in_state = V_FF; in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL hold_release_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL hold_no_accept_in_done got %b want 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL hold_idle_busy got %b want 0", busy); else passed++;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (busy !== 1'b1) $display("FAIL hold_accept_next got %b want 1", busy); else passed++;
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        total++; if (out_state !== R_FF) $display("FAIL hold_next_result got %h want %h", out_state, R_FF); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        in_state = V_SEQ; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_state !== '0) $display("FAIL rstmid_out_state got %h want 0", out_state); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else passed++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL rstmid_discarded got %0d want 0", seen); else passed++;
        in_state = V_FF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        total++; if (out_state !== R_FF) $display("FAIL rstmid_new_block got %h want %h", out_state, R_FF); else passed++;
        step();
    endtask

    task automatic test_ignore_busy();
        int n;
        in_state = V_SEQ; in_valid = 1'b1; out_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            in_state = V_FF;
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        total++; if (out_state !== R_SEQ) $display("FAIL ignore_busy_result got %h want %h", out_state, R_SEQ); else passed++;
        step();
        total++; if (in_ready !== 1'b1) $display("FAIL ignore_busy_idle got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_lanes();
        int first [4];
        logic [127:0] got [4];
        int want_lat [4];
        want_lat = '{16, 8, 2, 1};
        for (int j = 0; j < 4; j++) begin first[j] = -1; got[j] = SENT; end
        lv_in_state = V_SEQ; lv_in_valid = 1'b1; lv_out_ready = 1'b1;
        step();
        lv_in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            for (int j = 0; j < 4; j++) begin
                if (lv_out_valid[j] && first[j] < 0) begin
                    first[j] = i;
                    got[j] = lv_out_state[j];
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            total++; if (first[j] != want_lat[j]) $display("FAIL lanes_latency[%0d] got %0d want %0d", j, first[j], want_lat[j]); else passed++;
            total++; if (got[j] !== R_SEQ) $display("FAIL lanes_result[%0d] got %h want %h", j, got[j], R_SEQ); else passed++;
        end
        total++; if (lv_in_ready !== 4'hf) $display("FAIL lanes_idle got %b want 1111", lv_in_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_ignore_busy();
        test_lanes();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
